// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave UART transmitter: 8N1 serial output fed by a small TX FIFO,
// with TXDATA / STATUS / DIV registers and a programmable bit divider.
`timescale 1ns/1ps
module mfp_ahb_uart_tx #(
   parameter logic [15:0] DEFAULT_DIV = 16'd434,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic        UART_TX
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   logic          r_ap_valid;
   logic [1:0]    r_ap_addr;
   logic          r_ap_write;
   logic [15:0]   r_div;
   logic          r_ovf;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   state_t        r_state;
   logic [15:0]   r_timer;
   logic [15:0]   r_reload;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_tx;

   state_t        w_state_nxt;
   logic          w_pop;
   logic          w_wr;
   logic          w_rd;
   logic          w_tx_wr;
   logic          w_push;
   logic          w_status_rd;
   logic [AW:0]   w_count;
   logic [4:0]    w_count5;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_tick;
   logic [15:0]   w_div_eff;
   logic [31:0]   w_status;
   logic          w_unused;

   assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign UART_TX   = r_tx;

   assign w_wr        = r_ap_valid & r_ap_write;
   assign w_rd        = r_ap_valid & ~r_ap_write;
   assign w_tx_wr     = w_wr && (r_ap_addr == 2'd0);
   assign w_status_rd = w_rd && (r_ap_addr == 2'd1);
   assign w_count     = r_wptr - r_rptr;
   assign w_count5    = 5'(w_count);
   assign w_full      = (w_count == LP_DEPTH);
   assign w_empty     = (w_count == '0);
   // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
   assign w_push      = w_tx_wr && !w_full;
   assign w_busy      = (r_state != ST_IDLE);
   assign w_tick      = (r_timer == 16'd0);
   assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
   assign w_status    = {23'd0, w_count5, r_ovf, w_empty, w_full, w_busy};

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_ap_valid <= 1'b0;
         r_ap_addr  <= 2'd0;
         r_ap_write <= 1'b0;
         r_div      <= DEFAULT_DIV;
         r_ovf      <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_ap_valid <= HSEL & HTRANS[1] & HREADY;
         r_ap_addr  <= HADDR[3:2];
         r_ap_write <= HWRITE;
         if (w_wr && (r_ap_addr == 2'd2)) r_div <= HWDATA[15:0];
         if (w_tx_wr && w_full)           r_ovf <= 1'b1;
         else if (w_status_rd)            r_ovf <= 1'b0;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge HCLK) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= HWDATA[7:0];
   end

   always_comb begin
      HRDATA = 32'd0;
      if (w_rd) begin
         case (r_ap_addr)
            2'd1:    HRDATA = w_status;
            2'd2:    HRDATA = {16'd0, r_div};
            default: HRDATA = 32'd0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = ST_START;
               w_pop       = 1'b1;
            end
         end
         ST_START: if (w_tick) w_state_nxt = ST_DATA;
         ST_DATA:  if (w_tick && (r_bitcnt == 3'd7)) w_state_nxt = ST_STOP;
         ST_STOP: begin
            if (w_tick) begin
               if (!w_empty) begin
                  w_state_nxt = ST_START;
                  w_pop       = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The line level is registered alongside the state so it always matches the state entered.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state  <= ST_IDLE;
         r_timer  <= 16'd0;
         r_reload <= 16'd1;
         r_bitcnt <= 3'd0;
         r_shift  <= 8'd0;
         r_tx     <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_shift  <= r_mem[r_rptr[AW-1:0]];
            r_reload <= w_div_eff;
            r_timer  <= w_div_eff - 16'd1;
            r_bitcnt <= 3'd0;
            r_tx     <= 1'b0;
         end else if (r_state != ST_IDLE) begin
            if (w_tick) begin
               r_timer <= r_reload - 16'd1;
               case (r_state)
                  ST_START: r_tx <= r_shift[0];
                  ST_DATA: begin
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (r_bitcnt == 3'd7) begin
                        r_tx <= 1'b1;
                     end else begin
                        r_tx    <= r_shift[1];
                        r_shift <= {1'b0, r_shift[7:1]};
                     end
                  end
                  default: r_tx <= 1'b1;
               endcase
            end else begin
               r_timer <= r_timer - 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Self-checking bench for mfp_ahb_uart_tx: register vector table, serial-line
// scoreboard fed at write time and drained by a line monitor, plus corner sequences.
`timescale 1ns/1ps
module tb_mfp_ahb_uart_tx;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = 32'd0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'd2;
   logic        HREADY = 1'b1;
   logic [31:0] HWDATA = 32'd0;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic        UART_TX;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [23:0] exp_q[$];   // {div, byte} per expected frame
   int frame_start[$];
   bit mon_en = 1'b0;
   bit mon_busy = 1'b0;

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
   } vec_t;

   mfp_ahb_uart_tx #(.DEFAULT_DIV(16'd434), .FIFO_DEPTH(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .HRESP(HRESP), .UART_TX(UART_TX)
   );

   // ---------------- clock / reset ----------------
   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge HCLK); #1;
      end
   endtask

   task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      check("wr_dphase_hrdata", HRDATA, 32'd0);
      @(posedge HCLK); #1;
   endtask

   task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
      check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("hresp", {31'd0, HRESP}, 32'd0);
      @(posedge HCLK); #1;
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      ahb_read(a, d);
      check(name, d, exp);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
         @(posedge HCLK); n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0 || mon_busy) begin
         errors++;
         $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", exp_q.size(), budget);
      end
      tick(4);
   endtask

   // ---------------- scoreboard: serial line monitor ----------------
   initial begin : monitor
      logic        prev;
      logic [23:0] e;
      int          d;
      logic [7:0]  got;
      logic        stop_bit;
      logic        start_bit;
      bit          aborted;
      prev = 1'b1;
      forever begin
         @(negedge HCLK);
         if (mon_en && prev && !UART_TX) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
            end else begin
               mon_busy = 1'b1;
               e = exp_q.pop_front();
               d = int'(e[23:8]);
               frame_start.push_back(cyc);
               aborted = 1'b0;
               for (int j = 0; j < d / 2; j++) begin
                  @(negedge HCLK); if (!HRESETn) aborted = 1'b1;
               end
               start_bit = UART_TX;
               for (int b = 0; b < 8; b++) begin
                  for (int j = 0; j < d; j++) begin
                     @(negedge HCLK); if (!HRESETn) aborted = 1'b1;
                  end
                  got[b] = UART_TX;
               end
               for (int j = 0; j < d; j++) begin
                  @(negedge HCLK); if (!HRESETn) aborted = 1'b1;
               end
               stop_bit = UART_TX;
               if (!aborted) begin
                  check("start_bit", {31'd0, start_bit}, 32'd0);
                  check("frame_byte", {24'd0, got}, {24'd0, e[7:0]});
                  check("stop_bit", {31'd0, stop_bit}, 32'd1);
               end
               mon_busy = 1'b0;
            end
         end
         prev = UART_TX;
      end
   end

   // ---------------- test sequence ----------------
   initial begin : test
      vec_t        vecs[14];
      logic [31:0] rd;
      logic [7:0]  pat;
      logic [31:0] exp_bit;
      int          e0;
      int          m_count;
      bit          m_idle;
      bit          m_ovf;
      bit          m_pop;
      int          n_push;

      vecs[0]  = '{1'b0, 4'h4, 32'h0000_0004};
      vecs[1]  = '{1'b0, 4'h8, 32'h0000_01B2};
      vecs[2]  = '{1'b0, 4'h0, 32'h0000_0000};
      vecs[3]  = '{1'b0, 4'hC, 32'h0000_0000};
      vecs[4]  = '{1'b1, 4'hC, 32'hFFFF_FFFF};
      vecs[5]  = '{1'b0, 4'hC, 32'h0000_0000};
      vecs[6]  = '{1'b0, 4'h4, 32'h0000_0004};
      vecs[7]  = '{1'b0, 4'h8, 32'h0000_01B2};
      vecs[8]  = '{1'b1, 4'h8, 32'h0001_2345};
      vecs[9]  = '{1'b0, 4'h8, 32'h0000_2345};
      vecs[10] = '{1'b1, 4'h8, 32'h0000_0000};
      vecs[11] = '{1'b0, 4'h8, 32'h0000_0000};
      vecs[12] = '{1'b1, 4'h8, 32'h0000_0004};
      vecs[13] = '{1'b0, 4'h8, 32'h0000_0004};

      // reset state
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_uart_tx", {31'd0, UART_TX}, 32'd1);
      check("rst_hrdata", HRDATA, 32'd0);
      check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("rst_hresp", {31'd0, HRESP}, 32'd0);

      // TXDATA address phase overlapping the last reset edge must be ignored
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h55;
      @(posedge HCLK); #1;
      mon_en = 1'b1;
      read_check("rst_overlap_status", 4'h4, 32'h4);

      // register vector table
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) begin
            ahb_write(vecs[i].addr, vecs[i].data);
         end else begin
            ahb_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].data);
         end
      end
      check("uart_idle_after_regs", {31'd0, UART_TX}, 32'd1);

      // single frame 0xA5 at DIV=4, cycle-exact line pattern
      pat = 8'hA5;
      exp_q.push_back({16'd4, pat});
      ahb_write(4'h0, 32'hA5);
      check("latency_edge_e", {31'd0, UART_TX}, 32'd1);
      for (int k = 0; k < 40; k++) begin
         tick(1);
         if (k < 4)       exp_bit = 32'd0;
         else if (k < 36) exp_bit = {31'd0, pat[(k - 4) / 4]};
         else             exp_bit = 32'd1;
         check($sformatf("a5_line_k%0d", k), {31'd0, UART_TX}, exp_bit);
      end
      read_check("status_idle_after_frame", 4'h4, 32'h4);
      drain(200);

      // six back-to-back writes; a small FIFO/FSM model decides what is accepted
      frame_start.delete();
      m_count = 0; m_idle = 1'b1; m_ovf = 1'b0; n_push = 0;
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
         end else begin
            HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
         end
         if (i > 0) HWDATA = 32'(i);
         @(posedge HCLK); #1;
         if (i > 0) begin
            m_pop = m_idle && (m_count > 0);
            if (m_count < 4) begin
               exp_q.push_back({16'd4, 8'(i)});
               m_count++;
               n_push++;
            end else begin
               m_ovf = 1'b1;
            end
            if (m_pop) begin
               m_count--;
               m_idle = 1'b0;
            end
         end
      end
      check("burst_model_ovf", {31'd0, m_ovf}, 32'd1);
      read_check("burst_status_ovf", 4'h4,
                 (32'(m_count) << 4) | (32'(m_ovf) << 3) | (32'(m_count == 0) << 2) |
                 (32'(m_count == 4) << 1) | 32'(!m_idle));
      read_check("burst_status_ovf_clr", 4'h4,
                 (32'(m_count) << 4) | (32'(m_count == 0) << 2) |
                 (32'(m_count == 4) << 1) | 32'(!m_idle));
      drain(600);
      check("burst_frames", frame_start.size(), n_push);
      for (int i = 1; i < frame_start.size(); i++)
         check($sformatf("burst_gap%0d", i), frame_start[i] - frame_start[i - 1], 40);

      // full FIFO, 5th write lands on the same edge as the first pop
      frame_start.delete();
      exp_q.push_back({16'd4, 8'h10});
      ahb_write(4'h0, 32'h10);
      e0 = cyc;
      for (int v = 8'h11; v <= 8'h14; v++) begin
         exp_q.push_back({16'd4, 8'(v)});
         ahb_write(4'h0, 32'(v));
      end
      read_check("full_status", 4'h4, 32'h43);
      while (cyc < e0 + 39) tick(1);
      ahb_write(4'h0, 32'h15);
      read_check("pop_push_status", 4'h4, 32'h39);
      read_check("pop_push_status_clr", 4'h4, 32'h31);
      drain(600);
      check("pop_push_frames", frame_start.size(), 5);

      // DIV change mid-frame applies at the next start only
      frame_start.delete();
      exp_q.push_back({16'd4, 8'h3C});
      ahb_write(4'h0, 32'h3C);
      tick(10);
      ahb_write(4'h8, 32'h8);
      exp_q.push_back({16'd8, 8'hC3});
      ahb_write(4'h0, 32'hC3);
      read_check("div_read_8", 4'h8, 32'h8);
      drain(600);
      check("div_frames", frame_start.size(), 2);
      if (frame_start.size() == 2)
         check("div_gap", frame_start[1] - frame_start[0], 40);
      ahb_write(4'h8, 32'h4);

      // reset during data bit 5 with two bytes queued
      exp_q.push_back({16'd4, 8'h5A});
      exp_q.push_back({16'd4, 8'h11});
      exp_q.push_back({16'd4, 8'h22});
      ahb_write(4'h0, 32'h5A);
      e0 = cyc;
      ahb_write(4'h0, 32'h11);
      ahb_write(4'h0, 32'h22);
      read_check("midframe_status", 4'h4, 32'h21);
      while (cyc < e0 + 26) tick(1);
      HRESETn = 1'b0;
      tick(1);
      check("rst_mid_uart_tx", {31'd0, UART_TX}, 32'd1);
      exp_q.delete();
      HRESETn = 1'b1;
      read_check("rst_mid_status", 4'h4, 32'h4);
      read_check("rst_mid_div", 4'h8, 32'h1B2);
      tick(200);
      check("rst_mid_line_idle", {31'd0, UART_TX}, 32'd1);
      read_check("rst_mid_status_late", 4'h4, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
